// File: rtl/nanosoc_busmatrix_output_arbiter.sv
// Round-robin address-phase arbiter for one bus-matrix output port, with data-phase owner tracking.
// Optional burst hold (fixed-length bursts never split) is built when NANOSOC_BUSMATRIX_ARB_BURST_HOLD_EN is defined.
module nanosoc_busmatrix_output_arbiter #(
    parameter int NUM_PORTS = 3
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [NUM_PORTS-1:0]     REQ,
    input  logic [2*NUM_PORTS-1:0]   HTRANS_IN,
    input  logic [3*NUM_PORTS-1:0]   HBURST_IN,
    input  logic [NUM_PORTS-1:0]     HMASTLOCK_IN,
    input  logic                     HREADYM,
    output logic [NUM_PORTS-1:0]     ADDR_SEL,
    output logic                     ADDR_ACTIVE,
    output logic [NUM_PORTS-1:0]     DATA_SEL,
    output logic                     DATA_ACTIVE,
    output logic                     NO_PORT
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam logic [1:0] TRANS_BUSY = 2'b01;
    localparam logic [1:0] TRANS_SEQ  = 2'b11;
    localparam logic [NUM_PORTS-1:0] PORT0_SEL = {{(NUM_PORTS-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_RESET  = PW'(NUM_PORTS - 1);
    localparam logic [PW:0]   PORT_COUNT = (PW+1)'(NUM_PORTS);

    logic [NUM_PORTS-1:0] grant_r;
    logic [PW-1:0]        ptr_r;
    logic [NUM_PORTS-1:0] data_sel_r;
    logic                 data_active_r;

    logic [1:0]    htrans_g_s;
    logic          req_g_s;
    logic          lock_g_s;
    logic          addr_active_s;
    logic          burst_hold_s;
    logic          hold_s;
    logic          arb_s;
    logic          any_req_s;
    logic [PW-1:0] next_ptr_s;

    // Select the control signals of the port that currently owns the address phase.
    always_comb begin
        htrans_g_s = 2'b00;
        req_g_s    = 1'b0;
        lock_g_s   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            htrans_g_s = htrans_g_s | (HTRANS_IN[2*i +: 2] & {2{grant_r[i]}});
            req_g_s    = req_g_s    | (REQ[i] & grant_r[i]);
            lock_g_s   = lock_g_s   | (HMASTLOCK_IN[i] & grant_r[i]);
        end
    end

    assign addr_active_s = req_g_s & htrans_g_s[1];

`ifdef NANOSOC_BUSMATRIX_ARB_BURST_HOLD_EN
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    logic [3:0] bcnt_r;
    logic [3:0] bcnt_upd_s;
    logic [2:0] hburst_g_s;

    // Remaining SEQ beats after a NONSEQ of the given burst type.
    function automatic logic [3:0] burst_len_f(input logic [2:0] hburst);
        logic [3:0] len;
        case (hburst)
            3'd2, 3'd3: len = 4'd3;
            3'd4, 3'd5: len = 4'd7;
            3'd6, 3'd7: len = 4'd15;
            default:    len = 4'd0;
        endcase
        return len;
    endfunction

    // Select the burst type of the granted port.
    always_comb begin
        hburst_g_s = 3'b000;
        for (int i = 0; i < NUM_PORTS; i++) begin
            hburst_g_s = hburst_g_s | (HBURST_IN[3*i +: 3] & {3{grant_r[i]}});
        end
    end

    // Beat count after this cycle if it completes; BUSY pauses, anything non-active else ends the burst.
    always_comb begin
        bcnt_upd_s = bcnt_r;
        if (addr_active_s) begin
            if (htrans_g_s == TRANS_NONSEQ) begin
                bcnt_upd_s = burst_len_f(hburst_g_s);
            end else if (bcnt_r != 4'd0) begin
                bcnt_upd_s = bcnt_r - 4'd1;
            end else begin
                bcnt_upd_s = 4'd0;
            end
        end else if (htrans_g_s == TRANS_BUSY) begin
            bcnt_upd_s = bcnt_r;
        end else begin
            bcnt_upd_s = 4'd0;
        end
    end

    // Beat counter advances only on completed phases.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            bcnt_r <= 4'd0;
        end else if (HREADYM) begin
            bcnt_r <= bcnt_upd_s;
        end
    end

    // Looking at the post-update count keeps the opening NONSEQ of a burst from re-arbitrating.
    assign burst_hold_s = (bcnt_upd_s != 4'd0);
`else
    logic hburst_unused_s;

    // Burst type only matters when burst hold is built in.
    assign hburst_unused_s = ^HBURST_IN;
    assign burst_hold_s    = 1'b0;
`endif

    assign hold_s = lock_g_s | (htrans_g_s == TRANS_SEQ) | (htrans_g_s == TRANS_BUSY) | burst_hold_s;
    assign arb_s  = HREADYM & ~hold_s;

    // Round-robin search starting one past the last winner, wrapping around.
    always_comb begin
        logic [PW:0] cand_v;
        logic        take_v;
        next_ptr_s = ptr_r;
        any_req_s  = 1'b0;
        cand_v     = {(PW+1){1'b0}};
        take_v     = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand_v = {1'b0, ptr_r} + (PW+1)'(k);
            if (cand_v >= PORT_COUNT) begin
                cand_v = cand_v - PORT_COUNT;
            end else begin
                cand_v = cand_v;
            end
            take_v     = ~any_req_s & REQ[cand_v[PW-1:0]];
            next_ptr_s = take_v ? cand_v[PW-1:0] : next_ptr_s;
            any_req_s  = any_req_s | take_v;
        end
    end

    // Grant and rotation pointer move only at arbitration points with a requester; otherwise park.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            grant_r <= PORT0_SEL;
            ptr_r   <= PTR_RESET;
        end else if (arb_s && any_req_s) begin
            grant_r <= PORT0_SEL << next_ptr_s;
            ptr_r   <= next_ptr_s;
        end
    end

    // Data-phase owner follows the address phase once it completes.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            data_sel_r    <= {NUM_PORTS{1'b0}};
            data_active_r <= 1'b0;
        end else if (HREADYM) begin
            data_sel_r    <= grant_r;
            data_active_r <= addr_active_s;
        end
    end

    assign ADDR_SEL    = grant_r;
    assign ADDR_ACTIVE = addr_active_s;
    assign NO_PORT     = ~addr_active_s;
    assign DATA_SEL    = data_sel_r;
    assign DATA_ACTIVE = data_active_r;

endmodule

// File: tb/tb_nanosoc_busmatrix_output_arbiter.sv
// Directed bench for nanosoc_busmatrix_output_arbiter (NUM_PORTS=3); expectations follow the
// NANOSOC_BUSMATRIX_ARB_BURST_HOLD_EN build setting.
module tb_nanosoc_busmatrix_output_arbiter;

    logic       HCLK;
    logic       HRESET;
    logic [2:0] REQ;
    logic [5:0] HTRANS_IN;
    logic [8:0] HBURST_IN;
    logic [2:0] HMASTLOCK_IN;
    logic       HREADYM;
    logic [2:0] ADDR_SEL;
    logic       ADDR_ACTIVE;
    logic [2:0] DATA_SEL;
    logic       DATA_ACTIVE;
    logic       NO_PORT;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    localparam logic [5:0] ALL_NS   = 6'b10_10_10;
    localparam logic [5:0] P1_SEQ   = 6'b10_11_10;
    localparam logic [5:0] P1_IDLE  = 6'b10_00_10;
    localparam logic [5:0] P2_IDLE  = 6'b00_10_10;
    localparam logic [8:0] INCR4_P1 = 9'b000_011_000;
    localparam logic [8:0] WRAP8_P1 = 9'b000_100_000;

    logic [2:0] exp1 [6];
    logic [2:0] exp2 [7];

    nanosoc_busmatrix_output_arbiter #(.NUM_PORTS(3)) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .REQ          (REQ),
        .HTRANS_IN    (HTRANS_IN),
        .HBURST_IN    (HBURST_IN),
        .HMASTLOCK_IN (HMASTLOCK_IN),
        .HREADYM      (HREADYM),
        .ADDR_SEL     (ADDR_SEL),
        .ADDR_ACTIVE  (ADDR_ACTIVE),
        .DATA_SEL     (DATA_SEL),
        .DATA_ACTIVE  (DATA_ACTIVE),
        .NO_PORT      (NO_PORT)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic [5:0] tr, input logic [8:0] hb,
                         input logic [2:0] lk, input logic rdy);
        REQ          = req;
        HTRANS_IN    = tr;
        HBURST_IN    = hb;
        HMASTLOCK_IN = lk;
        HREADYM      = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
`ifdef NANOSOC_BUSMATRIX_ARB_BURST_HOLD_EN
        exp1 = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
        exp2 = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
`else
        exp1 = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b010, 3'b100};
        exp2 = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b010, 3'b100};
`endif
        // Reset with no requests
        HRESET = 1'b1;
        drive(3'b000, 6'b0, 9'b0, 3'b000, 1'b1);
        tick();
        tick();
        HRESET = 1'b0;
        #1;
        chk("rst_addr_sel", ADDR_SEL, 3'b001);
        chk("rst_addr_active", ADDR_ACTIVE, 1'b0);
        chk("rst_no_port", NO_PORT, 1'b1);
        chk("rst_data_sel", DATA_SEL, 3'b000);
        chk("rst_data_active", DATA_ACTIVE, 1'b0);
        tick();
        chk("park_addr_sel", ADDR_SEL, 3'b001);
        chk("park_data_sel", DATA_SEL, 3'b001);
        chk("park_data_active", DATA_ACTIVE, 1'b0);

        // All ports request single transfers: strict rotation
        drive(3'b111, ALL_NS, 9'b0, 3'b000, 1'b1);
        chk("rr_parked_active", ADDR_ACTIVE, 1'b1);
        chk("rr_parked_no_port", NO_PORT, 1'b0);
        tick(); chk("rr_sel0", ADDR_SEL, 3'b001); chk("rr_dsel0", DATA_SEL, 3'b001);
        tick(); chk("rr_sel1", ADDR_SEL, 3'b010); chk("rr_dsel1", DATA_SEL, 3'b001);
        tick(); chk("rr_sel2", ADDR_SEL, 3'b100); chk("rr_dsel2", DATA_SEL, 3'b010);
        tick(); chk("rr_sel3", ADDR_SEL, 3'b001); chk("rr_dsel3", DATA_SEL, 3'b100);
        chk("rr_dactive", DATA_ACTIVE, 1'b1);

        // Port 1 INCR4 while ports 0 and 2 keep requesting
        drive(3'b111, ALL_NS, INCR4_P1, 3'b000, 1'b1);
        tick(); chk("b1_a", ADDR_SEL, exp1[0]);
        tick(); chk("b1_b", ADDR_SEL, exp1[1]);
`ifdef NANOSOC_BUSMATRIX_ARB_BURST_HOLD_EN
        chk("b1_bcnt_load", dut.bcnt_r, 4'd3);
`endif
        drive(3'b111, P1_SEQ, INCR4_P1, 3'b000, 1'b1);
        tick(); chk("b1_c", ADDR_SEL, exp1[2]);
        tick(); chk("b1_d", ADDR_SEL, exp1[3]);
        tick(); chk("b1_e", ADDR_SEL, exp1[4]); chk("b1_e_dsel", DATA_SEL, 3'b010);
        drive(3'b101, P1_IDLE, 9'b0, 3'b000, 1'b1);
        tick(); chk("b1_f", ADDR_SEL, exp1[5]);

        // Same burst with a two-cycle stall on beat 2
        drive(3'b111, ALL_NS, INCR4_P1, 3'b000, 1'b1);
        tick(); chk("b2_g", ADDR_SEL, 3'b001);
        tick(); chk("b2_h", ADDR_SEL, 3'b010);
        tick(); chk("b2_i", ADDR_SEL, exp2[0]);
        drive(3'b111, P1_SEQ, INCR4_P1, 3'b000, 1'b0);
        chk("b2_stall_active", ADDR_ACTIVE, 1'b1);
        tick(); chk("b2_j", ADDR_SEL, exp2[1]); chk("b2_j_dsel", DATA_SEL, 3'b010);
        tick(); chk("b2_k", ADDR_SEL, exp2[2]); chk("b2_k_dsel", DATA_SEL, 3'b010);
`ifdef NANOSOC_BUSMATRIX_ARB_BURST_HOLD_EN
        chk("b2_bcnt_frozen", dut.bcnt_r, 4'd3);
`endif
        drive(3'b111, P1_SEQ, INCR4_P1, 3'b000, 1'b1);
        tick(); chk("b2_l", ADDR_SEL, exp2[3]);
        tick(); chk("b2_m", ADDR_SEL, exp2[4]);
        tick(); chk("b2_n", ADDR_SEL, exp2[5]);
`ifdef NANOSOC_BUSMATRIX_ARB_BURST_HOLD_EN
        chk("b2_bcnt_done", dut.bcnt_r, 4'd0);
`endif
        drive(3'b101, P1_IDLE, 9'b0, 3'b000, 1'b1);
        tick(); chk("b2_o", ADDR_SEL, exp2[6]);

        // Port 2 locked over five transfers, then releases with IDLE
        drive(3'b111, ALL_NS, 9'b0, 3'b100, 1'b1);
        chk("lk_active", ADDR_ACTIVE, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("lk_hold", ADDR_SEL, 3'b100);
        end
        drive(3'b011, P2_IDLE, 9'b0, 3'b000, 1'b1);
        chk("lk_idle_no_port", NO_PORT, 1'b1);
        tick();
        chk("lk_release", ADDR_SEL, 3'b001);
        chk("lk_dsel", DATA_SEL, 3'b100);
        chk("lk_dactive", DATA_ACTIVE, 1'b0);

        // Reset during beat 3 of a port-1 WRAP8
        drive(3'b111, ALL_NS, WRAP8_P1, 3'b000, 1'b1);
        tick(); chk("w8_grant", ADDR_SEL, 3'b010);
        tick();
        drive(3'b111, P1_SEQ, WRAP8_P1, 3'b000, 1'b1);
        tick();
`ifdef NANOSOC_BUSMATRIX_ARB_BURST_HOLD_EN
        chk("w8_bcnt_mid", dut.bcnt_r, 4'd6);
`endif
        HRESET = 1'b1;
        drive(3'b000, 6'b0, 9'b0, 3'b000, 1'b1);
        chk("mrst_addr_sel", ADDR_SEL, 3'b001);
        chk("mrst_addr_active", ADDR_ACTIVE, 1'b0);
        chk("mrst_no_port", NO_PORT, 1'b1);
        chk("mrst_data_sel", DATA_SEL, 3'b000);
        chk("mrst_data_active", DATA_ACTIVE, 1'b0);
`ifdef NANOSOC_BUSMATRIX_ARB_BURST_HOLD_EN
        chk("mrst_bcnt", dut.bcnt_r, 4'd0);
`endif
        tick();
        HRESET = 1'b0;
        drive(3'b111, ALL_NS, 9'b0, 3'b000, 1'b1);
        tick(); chk("post_rst_0", ADDR_SEL, 3'b001);
        tick(); chk("post_rst_1", ADDR_SEL, 3'b010);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/nanosoc_busmatrix_output_arbiter.md
# nanosoc_busmatrix_output_arbiter

Round-robin address-phase arbiter for one bus-matrix output (slave-side) port, sharing a single AHB slave between up to NUM_PORTS bus-matrix input ports. It decides which input port owns the output address phase and tracks which port owns the data phase, so the output stage can steer HADDR/HTRANS/HWDATA and return HRDATA/HREADYOUT/HRESP. It holds ownership across locked sequences and fixed-length bursts. When no port is granted, the output stage routes responses to the matrix default slave.

## Interface
- NUM_PORTS, 3: number of competing input ports (2..8).
- HCLK  in  1  AHB system clock.
- HRESET  in  1  asynchronous, active-high reset.
- REQ  in  NUM_PORTS  port i presents a valid transfer for this output (HSEL_i & HTRANS_i[1]), held by the input stage until accepted.
- HTRANS_IN  in  2*NUM_PORTS  HTRANS of each port; bits [2i+1:2i] belong to port i.
- HBURST_IN  in  3*NUM_PORTS  HBURST of each port; bits [3i+2:3i] belong to port i.
- HMASTLOCK_IN  in  NUM_PORTS  lock request of each port.
- HREADYM  in  1  HREADY of the output slave; high means the current phase completes.
- ADDR_SEL  out  NUM_PORTS  one-hot address-phase owner, registered.
- ADDR_ACTIVE  out  1  ADDR_SEL owner is driving a valid transfer.
- DATA_SEL  out  NUM_PORTS  one-hot data-phase owner, registered.
- DATA_ACTIVE  out  1  a data phase is in progress for DATA_SEL.
- NO_PORT  out  1  no valid address phase; output HTRANS forced IDLE.

## Operation
- Grant register g (one-hot), rotation pointer p, beat counter bcnt[3:0], lock flag.
- Arbitration point: a cycle with HREADYM=1 and hold=0. There the next g is the first port i with REQ[i]=1, searching from p+1 upward and wrapping. p then takes that index.
- No REQ at an arbitration point: g parks on its last value, ADDR_ACTIVE=0, NO_PORT=1.
- hold=1 if any of:
  - the granted port has HMASTLOCK_IN=1;
  - the granted port's HTRANS is SEQ or BUSY;
  - bcnt!=0 (burst-hold only).
- A locked port keeps the grant until it issues IDLE or NONSEQ with HMASTLOCK_IN=0 while HREADYM=1.
- ADDR_ACTIVE = REQ[granted] and the granted HTRANS[1]; NO_PORT = ~ADDR_ACTIVE.
- Data phase, on HREADYM=1: DATA_SEL<=ADDR_SEL and DATA_ACTIVE<=ADDR_ACTIVE. On HREADYM=0 both hold.
- Burst counter (burst-hold only), updated when HREADYM=1 and ADDR_ACTIVE=1:
  - NONSEQ with HBURST 2/3 loads bcnt=3; 4/5 loads 7; 6/7 loads 15; 0/1 loads 0.
  - SEQ decrements bcnt, saturating at 0.
  - IDLE or NONSEQ while bcnt!=0 means early termination; bcnt reloads per the new NONSEQ, or clears on IDLE.
- Reset mid-transfer: all state returns to reset values immediately; no partial burst is resumed.

## Timing
- Reset values: ADDR_SEL=1 (port 0 parked), ADDR_ACTIVE=0, DATA_SEL=0, DATA_ACTIVE=0, NO_PORT=1, p=NUM_PORTS-1, bcnt=0, lock=0.
- All outputs are registered or derived from registers plus REQ/HTRANS_IN of the granted port; there is no combinational path from HREADYM to ADDR_SEL.
- Grant latency: REQ asserted at a free arbitration point in cycle t gives ADDR_SEL for that port from cycle t+1. The data phase follows one completed address phase later.
- HREADYM=0 stalls every register except the outputs' combinational ADDR_ACTIVE/NO_PORT.
- Simultaneous REQ from all ports: grants rotate strictly, and each port is served within NUM_PORTS arbitration points.
- A requester is never starved. A locked port can starve others indefinitely by design.

## Configuration
- NANOSOC_BUSMATRIX_ARB_BURST_HOLD_EN defined: bcnt logic is present, and fixed-length bursts (INCR4/8/16, WRAP4/8/16) are never split between ports.
- Undefined: bcnt is removed (tied to 0). Hold comes only from lock and SEQ/BUSY on the granted port, so fixed bursts may be re-arbitrated at any NONSEQ or IDLE boundary.

## Test plan
- Reset, then NUM_PORTS=3 with REQ=3'b000 -> ADDR_SEL=001, ADDR_ACTIVE=0, NO_PORT=1, DATA_ACTIVE=0.
- REQ=3'b111, single NONSEQ transfers with HREADYM=1 -> ADDR_SEL sequence 001,010,100,001, and each DATA_SEL lags its ADDR_SEL by one cycle.
- Port 1 issues INCR4 (NONSEQ + 3 SEQ) while ports 0/2 request, with the macro defined -> grant stays 010 for 4 beats, then moves to 100.
- The same INCR4 burst with HREADYM=0 for 2 cycles on beat 2 -> bcnt, ADDR_SEL and DATA_SEL frozen, then the burst completes in 4 accepted beats.
- Port 2 sets HMASTLOCK with REQ=3'b111 over 5 transfers -> grant fixed at 100 until it issues IDLE with lock low, then moves to 001.
- HRESET pulsed during beat 3 of a WRAP8 burst -> all outputs at reset values in the same cycle, bcnt=0, and the next grant goes to port 0.
